imem_boot_loader: RTL and testbench

// Byte-stream writer for the single-cycle core's instruction memory: accepts a

---
 rtl/imem_boot_loader.sv | 193 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed little-endian byte image over a
// valid/ready port, packs it into 32-bit words and writes them to instruction
// memory from word 0 upward. Holds the core in reset until the image is fully
// written, then releases it. An oversized image parks the block in an error
// state that only rst clears.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Memory depth in words; widened so 2**ADDR_W itself is representable.
  localparam logic [16:0] DEPTH = 17'(2**ADDR_W);

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;      // image length in words
  logic [15:0]         word_q, word_d;        // index of the word being assembled
  logic [1:0]          lane_q, lane_d;        // byte position inside the word
  logic [23:0]         bytes_q, bytes_d;      // b0..b2 of the current word
  logic                s_ready_q, s_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;

  logic                accept;
  logic [15:0]         full_count;

  assign accept     = s_valid && s_ready_q;
  assign full_count = {s_data, count_q[7:0]};

  // Next-state and next-output logic of the loader FSM.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_d      = word_q;
    lane_d      = lane_q;
    bytes_d     = bytes_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_LEN0: begin
        if (accept) begin
          count_d = {8'h00, s_data};
          state_d = ST_LEN1;
        end else begin
          state_d = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          count_d = full_count;
          word_d  = 16'd0;
          lane_d  = 2'd0;
          if (full_count == 16'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, full_count} > DEPTH) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (accept) begin
          bytes_d = {s_data, bytes_q[23:8]};
          if (lane_q == 2'd3) begin
            // Fourth byte completes the word: issue a single-cycle write.
            mem_we_d    = 1'b1;
            mem_addr_d  = word_q[ADDR_W-1:0];
            mem_wdata_d = {s_data, bytes_q};
            lane_d      = 2'd0;
            word_d      = word_q + 16'd1;
            if (word_q == count_q - 16'd1) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        if (reload) begin
          state_d = ST_LEN0;
          count_d = 16'd0;
          word_d  = 16'd0;
          lane_d  = 2'd0;
          bytes_d = 24'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        // Unreachable encoding: keep the core in reset.
        state_d = ST_ERR;
      end
    endcase

    if ((state_d == ST_LEN0) || (state_d == ST_LEN1) || (state_d == ST_DATA)) begin
      s_ready_d = 1'b1;
    end else begin
      s_ready_d = 1'b0;
    end

    // Release lags entry into DONE by one edge so memory samples the last
    // write before the core starts fetching.
    if ((state_q == ST_DONE) && !reload) begin
      core_rst_n_d = 1'b1;
      load_done_d  = 1'b1;
    end else begin
      core_rst_n_d = 1'b0;
      load_done_d  = 1'b0;
    end

    if (state_d == ST_ERR) begin
      load_err_d = 1'b1;
    end else begin
      load_err_d = 1'b0;
    end
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LEN0;
      count_q      <= 16'd0;
      word_q       <= 16'd0;
      lane_q       <= 2'd0;
      bytes_q      <= 24'd0;
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      bytes_q      <= bytes_d;
      s_ready_q    <= s_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: byte-count based reference model, per-cycle
// output comparison, directed images plus randomized images and gaps.
module tb_imem_boot_loader;

  localparam int AW      = 10;
  localparam int DEPTH_M = 1024;

  logic          clk = 1'b0;
  logic          rst, rst2, s_valid, reload;
  logic [7:0]    s_data;
  logic          s_ready, mem_we, core_rst_n, load_done, load_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          s_ready2, mem_we2, core_rst_n2, load_done2, load_err2;
  logic [1:0]    mem_addr2;
  logic [31:0]   mem_wdata2;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err));

  imem_boot_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst2), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2),
    .reload(reload), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .core_rst_n(core_rst_n2), .load_done(load_done2), .load_err(load_err2));

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int we2_cnt = 0;
  logic cmp_en = 1'b0;
  logic rand_reload = 1'b0;
  logic [31:0] tb_mem [0:DEPTH_M-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: progress is tracked purely as bytes accepted since load start.
  logic        exp_ready = 1'b0, exp_we = 1'b0, exp_core = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0, m_word = 32'd0;
  int          m_n = 0, m_mode = 0, m_count = 0, k;   // mode: 0 loading, 1 finishing, 2 done, 3 error
  logic        m_acc;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_ready = 1'b0; exp_we = 1'b0; exp_core = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_addr = 32'd0; exp_wdata = 32'd0; m_word = 32'd0;
        m_n = 0; m_mode = 0; m_count = 0;
      end else begin
        m_acc  = s_valid && exp_ready;
        exp_we = 1'b0;
        if (m_mode == 0) begin
          if (m_acc) begin
            if (m_n == 0) begin
              m_count = int'(s_data);
            end else if (m_n == 1) begin
              m_count = m_count + 256 * int'(s_data);
              if (m_count == 0) m_mode = 1;
              else if (m_count > DEPTH_M) m_mode = 3;
            end else begin
              k = m_n - 2;
              m_word[8*(k%4) +: 8] = s_data;
              if (k % 4 == 3) begin
                exp_we    = 1'b1;
                exp_addr  = k / 4;
                exp_wdata = m_word;
                if (k / 4 == m_count - 1) m_mode = 1;
              end
            end
            m_n++;
          end
        end else if (m_mode == 1) begin
          m_mode = 2;
        end else if (m_mode == 2) begin
          if (reload) begin
            m_mode = 0; m_n = 0; m_count = 0;
          end
        end
        exp_ready = (m_mode == 0);
        exp_core  = (m_mode == 2);
        exp_done  = (m_mode == 2);
        exp_err   = (m_mode == 3);
      end
    end
  end

  // Per-cycle comparison of the main instance against the model; write capture.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("s_ready", s_ready, exp_ready);
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr[AW-1:0]);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("core_rst_n", core_rst_n, exp_core);
        chk("load_done", load_done, exp_done);
        chk("load_err", load_err, exp_err);
        if (mem_we === 1'b1) begin
          tb_mem[mem_addr] = mem_wdata;
          we_cnt++;
        end
        if (mem_we2 === 1'b1) we2_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input int gap, input int sel);
    int t;
    s_valid = 1'b0;
    reload  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = d;
    reload  = rand_reload ? ($urandom_range(3, 0) == 0) : 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (((sel == 0) ? s_ready : s_ready2) === 1'b1) break;
      t++;
      if (t > 50) begin
        checks++; errors++;
        $display("FAIL handshake: got no s_ready expected s_ready within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    reload  = 1'b0;
  endtask

  task automatic send_img(input logic [7:0] b[$], input int gmin, input int gmax, input int sel);
    foreach (b[i]) send(b[i], $urandom_range(gmax, gmin), sel);
  endtask

  task automatic do_reload();
    reload = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
    @(posedge clk); #1;
    reload = 1'b0; s_valid = 1'b0;
  endtask

  logic [7:0]  img2[$] = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'hA0, 8'h00};
  logic [7:0]  img5[$] = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
  logic [7:0]  q[$];
  logic [31:0] words[$];
  int          we0, n;
  logic [31:0] w;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; s_valid = 1'b1; s_data = 8'hA5; reload = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    idle(3);
    chk("rst s_ready", s_ready, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst core_rst_n", core_rst_n, 1'b0);
    rst = 1'b0; s_valid = 1'b0;
    idle(1);
    chk("ready after rst", s_ready, 1'b1);

    // Two-word image, back to back.
    we0 = we_cnt;
    send_img(img2, 0, 0, 0);
    idle(2);
    chk("t2 word0", tb_mem[0], 32'h00500293);
    chk("t2 word1", tb_mem[1], 32'h00A00313);
    chk("t2 writes", we_cnt - we0, 2);
    chk("t2 core_rst_n", core_rst_n, 1'b1);
    chk("t2 load_done", load_done, 1'b1);
    chk("t2 s_ready", s_ready, 1'b0);

    // Reload with a single-word image.
    do_reload();
    chk("t5 core_rst_n low", core_rst_n, 1'b0);
    chk("t5 load_done low", load_done, 1'b0);
    send_img(img5, 0, 0, 0);
    idle(2);
    chk("t5 word0", tb_mem[0], 32'h00100073);
    chk("t5 core_rst_n", core_rst_n, 1'b1);

    // Gapped stream.
    do_reload();
    we0 = we_cnt;
    send_img(img2, 3, 3, 0);
    idle(2);
    chk("t3 word0", tb_mem[0], 32'h00500293);
    chk("t3 word1", tb_mem[1], 32'h00A00313);
    chk("t3 writes", we_cnt - we0, 2);

    // Empty image.
    do_reload();
    we0 = we_cnt;
    q = '{8'h00, 8'h00};
    send_img(q, 0, 0, 0);
    chk("t4 core_rst_n pending", core_rst_n, 1'b0);
    idle(1);
    chk("t4 core_rst_n", core_rst_n, 1'b1);
    chk("t4 writes", we_cnt - we0, 0);

    // Reset in the middle of a word, then a fresh load.
    do_reload();
    tb_mem[0] = 32'd0; tb_mem[1] = 32'd0;
    we0 = we_cnt;
    q = '{8'h02, 8'h00, 8'h93, 8'h02};
    send_img(q, 0, 0, 0);
    rst = 1'b1;
    idle(2);
    chk("t6 writes", we_cnt - we0, 0);
    chk("t6 core_rst_n", core_rst_n, 1'b0);
    rst = 1'b0;
    idle(1);
    send_img(img2, 0, 0, 0);
    idle(2);
    chk("t6 word0", tb_mem[0], 32'h00500293);
    chk("t6 word1", tb_mem[1], 32'h00A00313);

    // Oversized image (1025 words) on the main instance.
    rst = 1'b1; idle(1); rst = 1'b0; idle(1);
    q = '{8'h01, 8'h04};
    send_img(q, 0, 0, 0);
    idle(2);
    chk("err load_err", load_err, 1'b1);
    chk("err core_rst_n", core_rst_n, 1'b0);
    do_reload();
    chk("err reload ignored", load_err, 1'b1);

    // Randomized images with random gaps and ignored reload pulses.
    for (int it = 0; it < 20; it++) begin
      rst = 1'b1; idle(1); rst = 1'b0; idle(1);
      n = $urandom_range(8, 1);
      q = {};
      words = {};
      q.push_back(8'(n));
      q.push_back(8'h00);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        words.push_back(w);
        for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
      end
      we0 = we_cnt;
      rand_reload = 1'b1;
      send_img(q, 0, 2, 0);
      rand_reload = 1'b0;
      idle(2);
      for (int i = 0; i < n; i++) chk("rand word", tb_mem[i], words[i]);
      chk("rand writes", we_cnt - we0, n);
      chk("rand core_rst_n", core_rst_n, 1'b1);
    end

    // Small-memory instance: COUNT == depth loads, COUNT == depth+1 errors.
    rst = 1'b1;
    rst2 = 1'b0;
    idle(1);
    q = '{8'h04, 8'h00};
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    we0 = we2_cnt;
    send_img(q, 0, 1, 1);
    idle(2);
    chk("aw2 full writes", we2_cnt - we0, 4);
    chk("aw2 full done", load_done2, 1'b1);
    chk("aw2 full err", load_err2, 1'b0);
    rst2 = 1'b1; idle(2); rst2 = 1'b0; idle(1);
    we0 = we2_cnt;
    q = '{8'h05, 8'h00};
    send_img(q, 0, 0, 1);
    idle(2);
    chk("aw2 over load_err", load_err2, 1'b1);
    chk("aw2 over core_rst_n", core_rst_n2, 1'b0);
    chk("aw2 over s_ready", s_ready2, 1'b0);
    chk("aw2 over writes", we2_cnt - we0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
